// File: rtl/dmx_tick_gen_if.sv
// dmx_tick_gen_if: control and status bundle of the DMX timebase.
// The framer drives the controls and watches the strobes.
interface dmx_tick_gen_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             oneshot;
    logic             start;
    logic [WIDTH-1:0] div;
    logic             div_load;
    logic             tick;
    logic             clk_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;

    modport master (
        output en, oneshot, start, div, div_load,
        input  tick, clk_out, busy, done, count
    );

    modport slave (
        input  en, oneshot, start, div, div_load,
        output tick, clk_out, busy, done, count
    );
endinterface

// File: rtl/dmx_tick_gen.sv
// dmx_tick_gen: programmable sysclk divider with tick, square wave
// and one-shot interval timing for the DMX transmit path.
module dmx_tick_gen #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 199
) (
    input logic            sysclk,
    input logic            reset,
    dmx_tick_gen_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] div_q, div_q_n;
    logic [WIDTH-1:0] div_pend, div_pend_n;
    logic             pend_flag, pend_n;
    logic             tick_q, tick_n;
    logic             done_q, done_n;
    logic             clk_q, clk_n;
    logic             wrap;

    assign wrap        = (count_q == div_q);
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
    assign bus.clk_out = clk_q;
    assign bus.count   = count_q;
    assign bus.busy    = (state == RUN);

    // State, counter and divisor registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count_q   <= '0;
            div_q     <= DEF;
            div_pend  <= '0;
            pend_flag <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            clk_q     <= 1'b1;
        end else begin
            state     <= state_n;
            count_q   <= count_n;
            div_q     <= div_q_n;
            div_pend  <= div_pend_n;
            pend_flag <= pend_n;
            tick_q    <= tick_n;
            done_q    <= done_n;
            clk_q     <= clk_n;
        end
    end

    // Next-state, counter, divisor staging and strobe decode.
    always_comb begin
        state_n    = state;
        count_n    = count_q;
        div_q_n    = div_q;
        div_pend_n = div_pend;
        pend_n     = pend_flag;
        tick_n     = 1'b0;
        done_n     = 1'b0;
        clk_n      = clk_q;
        if (!bus.en) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.div_load) begin
                        div_q_n = bus.div;
                        pend_n  = 1'b0;
                    end
                    if (!bus.oneshot || bus.start) begin
                        state_n = RUN;
                        count_n = '0;
                    end
                end
                RUN: begin
                    if (bus.start) begin
                        // Restart: no tick, but a boundary for staging.
                        count_n = '0;
                        if (wrap && pend_flag) begin
                            div_q_n = div_pend;
                            pend_n  = 1'b0;
                        end
                        if (bus.div_load) begin
                            div_q_n = bus.div;
                            pend_n  = 1'b0;
                        end
                    end else begin
                        if (bus.div_load) begin
                            div_pend_n = bus.div;
                            pend_n     = 1'b1;
                        end
                        if (wrap) begin
                            count_n = '0;
                            tick_n  = 1'b1;
                            clk_n   = ~clk_q;
                            if (pend_flag) begin
                                div_q_n = div_pend;
                                pend_n  = bus.div_load;
                            end
                            if (bus.oneshot) begin
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end
                        end else begin
                            count_n = count_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmx_tick_gen.sv
// tb_dmx_tick_gen: directed vectors; expected ticks are queued by the
// stimulus thread and checked by an independent tick monitor.
module tb_dmx_tick_gen;
    typedef struct {
        int at;
        bit clk;
        bit dn;
    } ev_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    bit   exp_clk = 1'b1;
    ev_t  q[$];

    dmx_tick_gen_if #(.WIDTH(16)) bus();

    dmx_tick_gen #(.WIDTH(16), .DEFAULT_DIV(199)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(int at, bit dn);
        ev_t e;
        exp_clk = ~exp_clk;
        e.at  = at;
        e.clk = exp_clk;
        e.dn  = dn;
        q.push_back(e);
    endtask

    task automatic at(int t);
        while (cyc < t) @(negedge sysclk);
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge sysclk);
            w++;
        end
        chk("drain", q.size(), 0);
    endtask

    // Monitor: every tick must match the head of the expected queue.
    always @(negedge sysclk) begin
        ev_t e;
        if (bus.tick) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: got tick want none (cyc %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("tick_cyc", cyc, e.at);
                chk("tick_clk", int'(bus.clk_out), int'(e.clk));
                chk("tick_done", int'(bus.done), int'(e.dn));
            end
        end else if (bus.done) begin
            total++;
            bad++;
            $display("FAIL done_no_tick: got done=1 want 0 (cyc %0d)", cyc);
        end
    end

    initial begin
        int c;
        int nb;
        bus.en       = 1'b0;
        bus.oneshot  = 1'b0;
        bus.start    = 1'b0;
        bus.div      = '0;
        bus.div_load = 1'b0;
        @(negedge sysclk);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_clk", int'(bus.clk_out), 1);
        chk("rst_count", int'(bus.count), 0);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);

        // Free-run, div=3: tick every 4 cycles.
        c = cyc;
        bus.en = 1'b1;
        bus.div = 16'd3;
        bus.div_load = 1'b1;
        push(c + 5, 0);
        push(c + 9, 0);
        push(c + 13, 0);
        push(c + 17, 0);
        @(negedge sysclk);
        bus.div_load = 1'b0;
        at(c + 2);
        chk("fr_busy", int'(bus.busy), 1);
        chk("fr_count", int'(bus.count), 1);
        // Drop en mid-period, then resume for a full period.
        at(c + 19);
        bus.en = 1'b0;
        at(c + 20);
        chk("en0_busy", int'(bus.busy), 0);
        chk("en0_count", int'(bus.count), 0);
        chk("en0_clk", int'(bus.clk_out), int'(exp_clk));
        at(c + 22);
        bus.en = 1'b1;
        push(c + 27, 0);
        at(c + 28);
        bus.en = 1'b0;
        drain();

        // One-shot, div=9: busy for exactly 10 cycles.
        c = cyc;
        bus.oneshot = 1'b1;
        bus.en = 1'b1;
        bus.start = 1'b1;
        bus.div_load = 1'b1;
        bus.div = 16'd9;
        push(c + 11, 1);
        nb = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge sysclk);
            bus.start = 1'b0;
            bus.div_load = 1'b0;
            if (bus.busy) nb++;
        end
        chk("os_busy_len", nb, 10);
        chk("os_count", int'(bus.count), 0);
        drain();

        // start together with div_load=5: tick 6 cycles later.
        c = cyc;
        bus.start = 1'b1;
        bus.div_load = 1'b1;
        bus.div = 16'd5;
        push(c + 7, 1);
        @(negedge sysclk);
        bus.start = 1'b0;
        bus.div_load = 1'b0;
        at(c + 9);
        drain();

        // Staging: div=7, load div=2 at count=3.
        c = cyc;
        bus.oneshot = 1'b0;
        bus.div_load = 1'b1;
        bus.div = 16'd7;
        push(c + 9, 0);
        push(c + 12, 0);
        push(c + 15, 0);
        @(negedge sysclk);
        bus.div_load = 1'b0;
        at(c + 4);
        bus.div_load = 1'b1;
        bus.div = 16'd2;
        @(negedge sysclk);
        bus.div_load = 1'b0;
        at(c + 15);
        bus.en = 1'b0;
        drain();

        // start exactly on the wrap edge: no tick, no toggle.
        c = cyc;
        bus.en = 1'b1;
        at(c + 3);
        bus.start = 1'b1;
        at(c + 4);
        bus.start = 1'b0;
        chk("sw_count", int'(bus.count), 0);
        chk("sw_tick", int'(bus.tick), 0);
        chk("sw_clk", int'(bus.clk_out), int'(exp_clk));
        push(c + 7, 0);
        push(c + 10, 0);
        at(c + 10);
        bus.en = 1'b0;
        drain();

        // div=0: tick every cycle.
        c = cyc;
        bus.en = 1'b1;
        bus.div_load = 1'b1;
        bus.div = 16'd0;
        for (int i = 2; i <= 6; i++) push(c + i, 0);
        @(negedge sysclk);
        bus.div_load = 1'b0;
        at(c + 6);
        bus.en = 1'b0;
        drain();

        // Reset mid-run, then default divisor 199.
        c = cyc;
        bus.en = 1'b1;
        bus.div_load = 1'b1;
        bus.div = 16'd9;
        push(c + 11, 0);
        @(negedge sysclk);
        bus.div_load = 1'b0;
        at(c + 13);
        #2 reset = 1'b0;
        #1;
        exp_clk = 1'b1;
        chk("mr_tick", int'(bus.tick), 0);
        chk("mr_done", int'(bus.done), 0);
        chk("mr_busy", int'(bus.busy), 0);
        chk("mr_clk", int'(bus.clk_out), 1);
        chk("mr_count", int'(bus.count), 0);
        at(c + 15);
        c = cyc;
        reset = 1'b1;
        push(c + 201, 0);
        at(c + 1);
        chk("mr_resume", int'(bus.busy), 1);
        at(c + 205);
        bus.en = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
